mult_block_driver: RTL and testbench

//  Host-side initiator/reader for the 64-entry block multiplier.
//  - Accepts operand pairs from an upstream valid/ready stream and issues them to the multiplier as EN_mult pulses.
//  - After 64 issues, requests a block read (EN_blockRead) and captures the 64 products.
//  - Replays the products downstream through a result FIFO with backpressure.

---
 rtl/mult_drv_pkg.sv | 16 +
 rtl/mult_result_fifo.sv | 53 +++++
 rtl/mult_block_driver.sv | 138 +++++++++++++
 tb/tb_mult_block_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_drv_pkg.sv
// Shared types and constants for the block multiplier driver.
package mult_drv_pkg;

  typedef enum logic [1:0] {
    ISSUE     = 2'd0,
    WAIT_FULL = 2'd1,
    REQ_READ  = 2'd2,
    COLLECT   = 2'd3
  } drv_state_t;

  // Multiplier block size is fixed by its 6-bit entry address.
  localparam int BLOCK_C = 64;
  // Issue/beat counters must hold the value BLOCK_C itself.
  localparam int CNT_W   = 7;

endpackage

// File: rtl/mult_result_fifo.sv
// Synchronous first-word-fall-through FIFO with async active-high reset.
// Push and pop may coincide at any fill level; a pop on empty is ignored.
// The head entry reads as zero while the FIFO is empty.
module mult_result_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEP = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEP);
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array, written at the tail; no reset needed on data.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks fill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mult_block_driver.sv
// Host-side initiator/reader for the 64-entry block multiplier.
// Issues operand pairs, requests a block read after BLOCK issues, captures
// the unthrottled read burst into a result FIFO and replays it downstream.
// Optional build macro MULT_DRV_CHECK_EN adds an expect FIFO of products
// and a sticky chk_err output flagging the first mismatching beat.
module mult_block_driver
  import mult_drv_pkg::*;
#(
  parameter int N          = 32,
  parameter int BLOCK      = BLOCK_C,
  parameter int FIFO_DEPTH = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_op0,
  input  logic [15:0]  in_op1,
  output logic         EN_mult,
  output logic [15:0]  mult_input0,
  output logic [15:0]  mult_input1,
  input  logic         RDY_mult,
  output logic         EN_blockRead,
  input  logic         VALID_memVal,
  input  logic [N-1:0] memVal_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         busy,
`ifdef MULT_DRV_CHECK_EN
  output logic         chk_err,
`endif
  output logic         proto_err
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int FW  = FAW + 1;
  localparam logic [CNT_W-1:0] BLK    = CNT_W'(BLOCK);
  localparam logic [CNT_W-1:0] BLK_M1 = CNT_W'(BLOCK - 1);
  localparam logic [FAW:0]     F_DEP  = FW'(FIFO_DEPTH);
  localparam logic [FAW:0]     F_BLK  = FW'(BLOCK);

  drv_state_t       state, state_nx;
  logic [CNT_W-1:0] issued, beat;
  logic             accept, capture, push_last, space_ok;
  logic [FAW:0]     fifo_cnt;
  logic [N:0]       fifo_head;

  assign accept    = EN_mult;
  assign capture   = VALID_memVal && (state == REQ_READ || state == COLLECT);
  assign push_last = (state == COLLECT) && (beat == BLK_M1);
  // The read burst cannot be throttled, so only request it when a whole block fits.
  assign space_ok  = (F_DEP - fifo_cnt) >= F_BLK;

  assign EN_mult     = in_valid && in_ready;
  assign mult_input0 = RST ? '0 : in_op0;
  assign mult_input1 = RST ? '0 : in_op1;
  assign busy        = (state != ISSUE) || (issued != '0);

  // Next-state and handshake outputs; forced low while reset is held.
  always_comb begin
    state_nx     = state;
    in_ready     = 1'b0;
    EN_blockRead = 1'b0;
    case (state)
      ISSUE: begin
        in_ready = RDY_mult && (issued < BLK);
        if (issued == BLK) state_nx = WAIT_FULL;
      end
      // RDY_mult drops once the multiplier pipeline has retired all entries.
      WAIT_FULL: if (!RDY_mult) state_nx = REQ_READ;
      REQ_READ: begin
        EN_blockRead = space_ok;
        if (VALID_memVal) state_nx = COLLECT;
      end
      COLLECT: if (VALID_memVal && beat == BLK_M1) state_nx = ISSUE;
      default: state_nx = ISSUE;
    endcase
    if (RST) begin
      in_ready     = 1'b0;
      EN_blockRead = 1'b0;
    end
  end

  // State, issue/beat counters and sticky protocol error.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ISSUE;
      issued    <= '0;
      beat      <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) issued <= issued + 1'b1;
      if (capture) beat <= (beat == BLK_M1) ? '0 : beat + 1'b1;
      if (push_last && capture) issued <= '0;
      if (VALID_memVal && !(state == REQ_READ || state == COLLECT)) proto_err <= 1'b1;
    end
  end

  mult_result_fifo #(.W(N + 1), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (capture),
    .push_data ({push_last, memVal_data}),
    .pop       (out_valid && out_ready),
    .pop_data  (fifo_head),
    .count     (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = fifo_head[N-1:0];
  assign out_last  = fifo_head[N];

`ifdef MULT_DRV_CHECK_EN
  logic [31:0]             prod, exp_prod;
  logic [$clog2(BLOCK):0]  exp_cnt;

  assign prod = {16'b0, in_op0} * {16'b0, in_op1};

  mult_result_fifo #(.W(32), .DEPTH(BLOCK)) u_exp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (accept),
    .push_data (prod),
    .pop       (capture),
    .pop_data  (exp_prod),
    .count     (exp_cnt)
  );

  // Sticky flag on the first captured beat that differs from its product.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) chk_err <= 1'b0;
    else if (capture && exp_cnt != '0 && memVal_data != N'(exp_prod)) chk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mult_block_driver.sv
// Bench for mult_block_driver: behavioural block multiplier, table-driven
// block checks and directed sequences for backpressure, protocol error,
// mid-burst reset and the optional product checker.
module tb_mult_block_driver;
  localparam int N = 32;

  logic CLK = 0, RST = 0;
  logic in_valid = 0, in_ready;
  logic [15:0] in_op0 = 0, in_op1 = 0;
  logic EN_mult, RDY_mult, EN_blockRead, VALID_memVal;
  logic [15:0] mult_input0, mult_input1;
  logic [N-1:0] memVal_data, out_data;
  logic out_valid, out_ready = 0, out_last, busy, proto_err;
`ifdef MULT_DRV_CHECK_EN
  logic chk_err;
`endif

  always #5 CLK = ~CLK;

  mult_block_driver #(.N(N), .BLOCK(64), .FIFO_DEPTH(64)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_op0(in_op0), .in_op1(in_op1),
    .EN_mult(EN_mult), .mult_input0(mult_input0), .mult_input1(mult_input1),
    .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy),
`ifdef MULT_DRV_CHECK_EN
    .chk_err(chk_err),
`endif
    .proto_err(proto_err)
  );

  // ---------------- behavioural multiplier ----------------
  logic [31:0] mmem [64];
  int   n_iss = 0, mst = 0, dly = 0, mbeat = 0, bursts = 0, iss_at_read = 0;
  logic mdl_valid = 0, rdy_low = 0, rnd_en = 0, corrupt = 0, inj = 0;
  logic [31:0] mdl_data = 0, inj_data = 0;

  assign RDY_mult     = (n_iss < 64) && !rdy_low;
  assign VALID_memVal = mdl_valid | inj;
  assign memVal_data  = inj ? inj_data : mdl_data;

  always @(posedge CLK) rdy_low <= rnd_en && ($urandom_range(0, 3) == 0);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      n_iss <= 0; mst <= 0; dly <= 0; mbeat <= 0; mdl_valid <= 0; mdl_data <= 0;
    end else begin
      mdl_valid <= 0;
      if (EN_mult) begin
        mmem[n_iss[5:0]] <= {16'b0, mult_input0} * {16'b0, mult_input1};
        n_iss <= n_iss + 1;
      end
      case (mst)
        0: if (EN_blockRead) begin mst <= 1; dly <= 0; bursts <= bursts + 1; iss_at_read <= n_iss; end
        1: if (dly == 2) begin mst <= 2; mbeat <= 0; end else dly <= dly + 1;
        default: begin
          mdl_valid <= 1;
          mdl_data  <= mmem[mbeat[5:0]] + ((corrupt && mbeat == 17) ? 32'd1 : 32'd0);
          mbeat     <= mbeat + 1;
          if (mbeat == 63) begin mst <= 0; n_iss <= 0; end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic [32:0] rq [$];
  int   n_en = 0, bad_en = 0, pops = 0, pops_at_rd = 0, cap_n = 0;
  logic prev_rd = 0;
  logic chk_hist [64];

  always @(negedge CLK) begin
    if (RST) begin
      cap_n   = 0;
      prev_rd = 0;
    end else begin
      if (EN_mult) begin
        n_en++;
        if (!RDY_mult || mult_input0 !== in_op0 || mult_input1 !== in_op1) bad_en++;
      end
      if (EN_blockRead && !prev_rd) pops_at_rd = pops;
      prev_rd = EN_blockRead;
      if (out_valid && out_ready) begin rq.push_back({out_last, out_data}); pops++; end
`ifdef MULT_DRV_CHECK_EN
      chk_hist[cap_n] = chk_err;
`endif
      if (VALID_memVal && !inj) begin cap_n++; if (cap_n == 64) cap_n = 0; end
    end
  end

  // ---------------- checking helpers ----------------
  typedef struct {
    logic [15:0] a, b;
    logic [31:0] exp;
    logic        last;
  } vec_t;
  vec_t tbl [64];
  int cmp = 0, fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    for (int k = 0; k < 64; k++) begin
      case (kind)
        0: begin tbl[k].a = 16'(k);       tbl[k].b = 16'(k + 1);     tbl[k].exp = 32'(k * (k + 1)); end
        1: begin tbl[k].a = 16'(k + 300); tbl[k].b = 16'(3 * k + 7); tbl[k].exp = 32'((k + 300) * (3 * k + 7)); end
        default: begin
          tbl[k].a = 16'(65535 - k); tbl[k].b = 16'hFFFF;
          tbl[k].exp = 32'(longint'(65535 - k) * 65535);
        end
      endcase
      tbl[k].last = (k == 63);
    end
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin @(posedge CLK); #1; end
    in_valid = 1; in_op0 = a; in_op1 = b;
    @(negedge CLK);
    while (!in_ready && t < 500) begin @(negedge CLK); t++; end
    if (!in_ready) begin
      cmp++; fails++;
      $display("FAIL feed_timeout: in_ready stuck 0 for %0d cycles, expected 1", t);
    end
    @(posedge CLK); #1;
    in_valid = 0;
  endtask

  task automatic feed_block(input int gapmax);
    for (int k = 0; k < 64; k++)
      feed(tbl[k].a, tbl[k].b, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  task automatic wait_rq(input string nm, input int n);
    int t;
    t = 0;
    while (rq.size() < n && t < 3000) begin @(posedge CLK); #1; t++; end
    chk({nm, "_count"}, (rq.size() >= n) ? 64'(n) : 64'(rq.size()), 64'(n));
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(posedge CLK); #1;
    while (busy && t < 3000) begin @(posedge CLK); #1; t++; end
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic check_block(input string nm);
    logic [32:0] r;
    for (int k = 0; k < 64; k++) begin
      if (rq.size() == 0) begin
        cmp++; fails++;
        $display("FAIL %s[%0d]: no result, expected %0h", nm, k, tbl[k].exp);
      end else begin
        r = rq.pop_front();
        chk($sformatf("%s_data[%0d]", nm, k), r[31:0], tbl[k].exp);
        chk($sformatf("%s_last[%0d]", nm, k), r[32], tbl[k].last);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int e0, b0, p0, t, hi;

    // Reset state, with upstream already presenting a pair.
    in_valid = 1; in_op0 = 16'hABCD; in_op1 = 16'h1234;
    #1 RST = 1;
    #11;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_en_mult", EN_mult, 0);
    chk("rst_mult_input0", mult_input0, 0);
    chk("rst_en_blockread", EN_blockRead, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);
    in_valid = 0;
    @(posedge CLK); #1 RST = 0;

    // 1: one block (k, k+1) with free-running downstream.
    out_ready = 1;
    fill(0);
    e0 = n_en;
    feed_block(0);
    wait_rq("t1", 64);
    check_block("t1");
    chk("t1_en_mult_pulses", n_en - e0, 64);
    chk("t1_issues_at_read", iss_at_read, 64);
    chk("t1_read_bursts", bursts, 1);
    wait_idle("t1");

    // 2: downstream stalled across two blocks; read of block 2 waits for drain.
    out_ready = 0;
    fill(1);
    feed_block(0);
    wait_idle("t2_blk1");
    chk("t2_out_valid_held", out_valid, 1);
    fill(2);
    feed_block(0);
    b0 = bursts; hi = 0;
    repeat (40) begin @(negedge CLK); if (EN_blockRead) hi++; end
    chk("t2_blockread_gated", hi, 0);
    chk("t2_no_new_burst", bursts - b0, 0);
    chk("t2_busy_waiting", busy, 1);
    @(posedge CLK); #1;
    p0 = pops;
    out_ready = 1;
    wait_rq("t2", 128);
    chk("t2_pops_before_read", pops_at_rd - p0, 64);
    fill(1); check_block("t2_blk1");
    fill(2); check_block("t2_blk2");
    wait_idle("t2");

    // 3: random issue gaps and RDY_mult dropouts.
    rnd_en = 1;
    fill(1);
    e0 = n_en;
    feed_block(3);
    rnd_en = 0;
    wait_rq("t3", 64);
    check_block("t3");
    chk("t3_en_mult_pulses", n_en - e0, 64);
    chk("t3_en_without_rdy", bad_en, 0);
    chk("t3_issues_at_read", iss_at_read, 64);
    wait_idle("t3");

    // 4: stray product beat while issuing.
    chk("t4_proto_err_before", proto_err, 0);
    inj = 1; inj_data = 32'h0000_1234;
    @(posedge CLK); #1 inj = 0;
    chk("t4_proto_err_set", proto_err, 1);
    chk("t4_fifo_untouched", out_valid, 0);
    repeat (5) @(posedge CLK);
    #1;
    chk("t4_proto_err_sticky", proto_err, 1);
    RST = 1; #1;
    chk("t4_proto_err_cleared", proto_err, 0);
    @(posedge CLK); #1 RST = 0;

    // 5: reset in the middle of the capture burst.
    out_ready = 0;
    fill(0);
    feed_block(0);
    t = 0;
    while (cap_n != 30 && t < 3000) begin @(posedge CLK); #2; t++; end
    chk("t5_reached_beat30", cap_n, 30);
    chk("t5_out_valid_pre", out_valid, 1);
    in_valid = 1; in_op0 = 16'h5A5A;
    RST = 1; #1;
    chk("t5_in_ready", in_ready, 0);
    chk("t5_en_mult", EN_mult, 0);
    chk("t5_mult_input0", mult_input0, 0);
    chk("t5_en_blockread", EN_blockRead, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_busy", busy, 0);
    in_valid = 0;
    @(posedge CLK); #1 RST = 0;
    out_ready = 1;
    rq.delete();
    fill(2);
    e0 = n_en;
    feed_block(0);
    wait_rq("t5", 64);
    check_block("t5");
    repeat (5) @(posedge CLK);
    #1;
    chk("t5_no_leftover", rq.size(), 0);
    chk("t5_en_mult_pulses", n_en - e0, 64);
    chk("t5_issues_at_read", iss_at_read, 64);

`ifdef MULT_DRV_CHECK_EN
    // 6: corrupted beat 17 trips the product checker.
    chk("t6_chk_err_before", chk_err, 0);
    corrupt = 1;
    fill(0);
    feed_block(0);
    wait_rq("t6", 64);
    corrupt = 0;
    tbl[17].exp = tbl[17].exp + 32'd1;
    check_block("t6");
    chk("t6_chk_err_pre17", chk_hist[17], 0);
    chk("t6_chk_err_at17", chk_hist[18], 1);
    chk("t6_chk_err_sticky", chk_err, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
